// File: rtl/rgmii_tx_pkg.sv
// State encoding and Ethernet framing constants for the RGMII transmit scheduler.
package rgmii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  ETH_PRE     = 8'h55;
    localparam logic [7:0]  ETH_SFD     = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam int          PREAMBLE_LEN = 8;
    localparam int          FCS_LEN      = 4;

endpackage

// File: rtl/rgmii_tx_sched_crc32.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Kept standalone so the receive-side checker can reuse it unchanged.
module eth_crc32_byte
    import rgmii_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    always_comb begin
        // NOTE: blocking assignments chain the eight bit-steps inside one evaluation.
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data_in[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/rgmii_tx_sched.sv
// Round-robin frame scheduler feeding the GMII-style byte path of an RGMII transmitter:
// adds preamble/SFD, zero-pads short frames, appends FCS and enforces the inter-frame gap.
module rgmii_tx_sched
    import rgmii_tx_pkg::*;
#(
    parameter int  NUM_SRC     = 2,
    parameter int  IFG_BYTES   = 12,
    parameter int  MIN_PAYLOAD = 60,
    localparam int GW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_enable,
    input  logic [NUM_SRC*8-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]   s_tvalid,
    input  logic [NUM_SRC-1:0]   s_tlast,
    output logic [NUM_SRC-1:0]   s_tready,
    output logic [7:0]           gmii_txd,
    output logic                 gmii_tx_en,
    output logic                 gmii_tx_er,
    output logic [GW-1:0]        grant,
    output logic                 busy
);

    tx_state_e     state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   idx_q, idx_d;
    logic [31:0]   crc_q, crc_d;
    logic [7:0]    txd_q, txd_d;
    logic          tx_en_q, tx_en_d;
    logic          tx_er_q, tx_er_d;

    logic [GW-1:0] arb_idx, arb_rr_next, cand;
    logic          arb_hit, arb_now;
    logic          src_valid, src_last;
    logic [7:0]    src_data, crc_byte, fcs_byte;
    logic [31:0]   crc_next;

    assign src_valid = s_tvalid[grant_q];
    assign src_last  = s_tlast[grant_q];
    assign src_data  = s_tdata[{grant_q, 3'b000} +: 8];
    assign crc_byte  = (state_q == ST_PAD) ? 8'h00 : src_data;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data_in (crc_byte),
        .crc_out (crc_next)
    );

    always_comb begin
        unique case (idx_q[1:0])
            2'd0:    fcs_byte = ~crc_q[7:0];
            2'd1:    fcs_byte = ~crc_q[15:8];
            2'd2:    fcs_byte = ~crc_q[23:16];
            default: fcs_byte = ~crc_q[31:24];
        endcase
    end

    // Lowest offset from the RR pointer wins, so scan offsets from high to low.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = rr_q;
        cand    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_q) + k) % NUM_SRC);
            if (s_tvalid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
        arb_rr_next = GW'((int'(arb_idx) + 1) % NUM_SRC);
    end

    // The final IFG byte time doubles as an IDLE cycle so back-to-back gaps are exact.
    assign arb_now = (state_q == ST_IDLE) ||
                     ((state_q == ST_IFG) && (int'(idx_q) >= IFG_BYTES - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        crc_d   = crc_q;
        txd_d   = 8'h00;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                if (int'(idx_q) == PREAMBLE_LEN - 1) begin
                    txd_d   = ETH_SFD;
                    idx_d   = '0;
                    state_d = ST_PAYLOAD;
                end else begin
                    txd_d = ETH_PRE;
                    idx_d = idx_q + 16'd1;
                end
            end
            ST_PAYLOAD: begin
                tx_en_d = 1'b1;
                if (src_valid) begin
                    txd_d = src_data;
                    crc_d = crc_next;
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    if (src_last) begin
                        idx_d   = '0;
                        state_d = (int'(cnt_q) + 1 < MIN_PAYLOAD) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    tx_er_d = 1'b1;
                end
            end
            ST_PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_next;
                cnt_d   = cnt_q + 16'd1;
                if (int'(cnt_q) + 1 >= MIN_PAYLOAD) begin
                    idx_d   = '0;
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_byte;
                if (int'(idx_q) == FCS_LEN - 1) begin
                    idx_d   = '0;
                    state_d = ST_IFG;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            ST_IFG: begin
                idx_d = idx_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (arb_now) begin
            idx_d = '0;
            if (arb_hit) begin
                grant_d = arb_idx;
                rr_d    = arb_rr_next;
                cnt_d   = '0;
                crc_d   = CRC_INIT;
                state_d = ST_PREAMBLE;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: this block holds only control registers, so every one of them takes a reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            crc_q   <= CRC_INIT;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
        end
    end

    always_comb begin
        s_tready = '0;
        if (clk_enable && (state_q == ST_PAYLOAD)) begin
            s_tready[grant_q] = 1'b1;
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign grant      = grant_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rgmii_tx_sched.sv
// Scoreboard bench for rgmii_tx_sched: drivers feed queued frames, a monitor rebuilds
// each transmitted frame and compares it with the framing rules applied to the payload.
module tb_rgmii_tx_sched;
    import rgmii_tx_pkg::*;

    localparam int N    = 2;
    localparam int IFG  = 12;
    localparam int MINP = 60;
    localparam int MAXF = 128;
    localparam int MAXL = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clk_enable = 1'b1;
    logic [N*8-1:0] s_tdata;
    logic [N-1:0]   s_tvalid, s_tlast, s_tready;
    logic [7:0]     gmii_txd;
    logic           gmii_tx_en, gmii_tx_er, busy;
    logic [0:0]     grant;

    rgmii_tx_sched #(.NUM_SRC(N), .IFG_BYTES(IFG), .MIN_PAYLOAD(MINP)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame table: payload bytes plus the stall pattern the driver applies.
    logic [7:0] fr_data [MAXF][MAXL];
    int         fr_len [MAXF];
    int         fr_stall_at [MAXF];
    int         fr_stall_n [MAXF];
    int         nfr = 0;
    int         dq [N][$];
    int         pend [N][$];
    int         acc_cnt [N];
    int         rdy_cnt [N];
    int         m_rr = 0;
    int         gaps [$];
    int         grants [$];
    bit         in_frame = 1'b0;
    int         en_div = 1;
    int         en_cnt = 0;
    logic [31:0] crc_tab [256];
    logic [7:0]  rx [MAXL];

    function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
        return crc_tab[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    function automatic logic [31:0] bitrev32(logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    task automatic send(int src, int len, bit pattern, int stall_at, int stall_n);
        int id;
        id = nfr;
        check("frame_table_room", id < MAXF, 1);
        if (id < MAXF) begin
            nfr++;
            fr_len[id]      = len;
            fr_stall_at[id] = stall_at;
            fr_stall_n[id]  = stall_n;
            for (int b = 0; b < len; b++) fr_data[id][b] = pattern ? 8'(b) : 8'($urandom);
            dq[src].push_back(id);
            pend[src].push_back(id);
        end
    endtask

    task automatic check_frame(int fid, int nb, int ers);
        int plen, lim, nmis, first;
        logic [31:0] c, r;
        logic [7:0]  e;
        plen  = (fr_len[fid] < MINP) ? MINP : fr_len[fid];
        lim   = (nb < 8 + plen + 4) ? nb : 8 + plen + 4;
        c     = CRC_INIT;
        nmis  = 0;
        first = -1;
        check($sformatf("frame%0d_len", fid), nb, 8 + plen + 4);
        check($sformatf("frame%0d_err_bytes", fid), ers, fr_stall_n[fid]);
        for (int b = 0; b < lim; b++) begin
            if (b < 7) e = ETH_PRE;
            else if (b == 7) e = ETH_SFD;
            else if (b < 8 + plen) begin
                e = (b - 8 < fr_len[fid]) ? fr_data[fid][b-8] : 8'h00;
                c = crc_upd(c, e);
            end else begin
                e = 8'(~c >> (8 * (b - 8 - plen)));
            end
            if (rx[b] !== e) begin
                nmis++;
                if (first < 0) first = b;
            end
        end
        check($sformatf("frame%0d_byte_mismatches first_at=%0d", fid, first), nmis, 0);
        r = CRC_INIT;
        for (int b = 8; b < nb; b++) r = crc_upd(r, rx[b]);
        check($sformatf("frame%0d_residue", fid), bitrev32(r), CRC_RESIDUE);
    endtask

    initial begin : en_gen
        forever begin
            @(posedge clk);
            #1;
            en_cnt++;
            clk_enable = ((en_cnt % en_div) == 0);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_drv
        logic       v = 1'b0;
        logic       l = 1'b0;
        logic [7:0] d = 8'h00;
        assign s_tvalid[g]       = v;
        assign s_tlast[g]        = l;
        assign s_tdata[8*g +: 8] = d;

        initial begin
            int fid, pos, left;
            bit active, acc, stl;
            fid = 0; pos = 0; left = 0; active = 1'b0;
            forever begin
                @(negedge clk);
                acc = v && s_tready[g];
                stl = active && !v && s_tready[g];
                @(posedge clk);
                #1;
                if (rst) begin
                    active = 1'b0;
                end else begin
                    if (acc) begin
                        pos++;
                        acc_cnt[g]++;
                        if (pos == fr_len[fid]) active = 1'b0;
                    end
                    if (stl && left > 0) left--;
                    if (!active && dq[g].size() > 0) begin
                        fid    = dq[g].pop_front();
                        pos    = 0;
                        left   = fr_stall_n[fid];
                        active = 1'b1;
                    end
                end
                if (active && !(pos == fr_stall_at[fid] && left > 0)) begin
                    v = 1'b1;
                    d = fr_data[fid][pos];
                    l = (pos == fr_len[fid] - 1);
                end else begin
                    v = 1'b0;
                    l = 1'b0;
                    d = 8'h00;
                end
            end
        end
    end

    initial begin : monitor
        int nb, ers, fid, gap, src;
        bit have_prev, last_en, last_rst;
        logic [7:0] p_txd;
        logic       p_en, p_er;
        nb = 0; ers = 0; fid = -1; gap = 0;
        have_prev = 1'b0; last_en = 1'b1; last_rst = 1'b1;
        p_txd = 8'h00; p_en = 1'b0; p_er = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame  = 1'b0;
                have_prev = 1'b0;
                last_rst  = 1'b1;
            end else begin
                if (!last_en && !last_rst)
                    check("hold_while_disabled", {p_txd, p_en, p_er}, {gmii_txd, gmii_tx_en, gmii_tx_er});
                if (!clk_enable) check("tready_while_disabled", s_tready, '0);
                p_txd = gmii_txd; p_en = gmii_tx_en; p_er = gmii_tx_er;
                last_rst = 1'b0;
                if (clk_enable) begin
                    for (int k = 0; k < N; k++) if (s_tready[k]) rdy_cnt[k]++;
                    if (gmii_tx_en) begin
                        if (!in_frame) begin
                            in_frame = 1'b1;
                            nb = 0;
                            ers = 0;
                            src = -1;
                            for (int k = 0; k < N; k++)
                                if (src < 0 && pend[(m_rr + k) % N].size() > 0) src = (m_rr + k) % N;
                            check("frame_expected", src >= 0, 1);
                            fid = -1;
                            if (src >= 0) begin
                                fid  = pend[src].pop_front();
                                m_rr = (src + 1) % N;
                                grants.push_back(src);
                                check("grant", grant, src);
                                check("busy_in_frame", busy, 1);
                            end
                            if (have_prev) gaps.push_back(gap);
                        end
                        if (gmii_tx_er) begin
                            ers++;
                            check("err_byte_txd", gmii_txd, 8'h00);
                        end else if (nb < MAXL) begin
                            rx[nb] = gmii_txd;
                            nb++;
                        end
                    end else begin
                        check("tx_er_idle", gmii_tx_er, 0);
                        if (in_frame) begin
                            in_frame = 1'b0;
                            if (fid >= 0) check_frame(fid, nb, ers);
                            gap = 1;
                            have_prev = 1'b1;
                        end else begin
                            gap++;
                        end
                    end
                end
            end
            last_en = clk_enable;
        end
    end

    task automatic wait_done(int budget);
        int t, np;
        t = 0;
        forever begin
            np = 0;
            for (int k = 0; k < N; k++) np += pend[k].size();
            if ((np == 0 && !in_frame) || t >= budget) break;
            @(posedge clk);
            t++;
        end
        check("wait_within_budget", t < budget, 1);
        repeat ((IFG + 4) * en_div) @(posedge clk);
    endtask

    initial begin : main
        int base, t, len, sa, sn;
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
            crc_tab[n] = c;
        end
        for (int k = 0; k < N; k++) begin acc_cnt[k] = 0; rdy_cnt[k] = 0; end

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_tx_en", gmii_tx_en, 0);
        check("rst_tx_er", gmii_tx_er, 0);
        check("rst_tready", s_tready, '0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);

        send(0, 64, 1'b1, -1, 0);
        wait_done(3000);

        base = rdy_cnt[1];
        send(1, 10, 1'b1, -1, 0);
        wait_done(3000);
        check("src1_tready_cycles", rdy_cnt[1] - base, 10);

        gaps.delete();
        grants.delete();
        send(0, 64, 1'b0, -1, 0);
        send(1, 64, 1'b0, -1, 0);
        send(0, 64, 1'b0, -1, 0);
        send(1, 64, 1'b0, -1, 0);
        wait_done(6000);
        check("rr_grant_count", grants.size(), 4);
        if (grants.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), grants[i], i % 2);
        check("rr_gap_count", gaps.size(), 4);
        if (gaps.size() == 4)
            for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), gaps[i], IFG);

        en_div = 10;
        repeat (20) @(posedge clk);
        base = acc_cnt[0];
        send(0, 64, 1'b1, -1, 0);
        wait_done(20000);
        check("slow_accepted", acc_cnt[0] - base, 64);
        en_div = 1;
        repeat (20) @(posedge clk);

        send(0, 64, 1'b1, 20, 2);
        wait_done(3000);

        base = acc_cnt[1];
        send(1, 64, 1'b0, -1, 0);
        t = 0;
        while (acc_cnt[1] - base < 30 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check("reached_byte30", t < 5000, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx_en", gmii_tx_en, 0);
        check("midrst_tready", s_tready, '0);
        check("midrst_busy", busy, 0);
        for (int k = 0; k < N; k++) begin dq[k].delete(); pend[k].delete(); end
        m_rr = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        grants.delete();
        send(1, 20, 1'b0, -1, 0);
        send(0, 20, 1'b0, -1, 0);
        wait_done(4000);
        check("post_rst_grant_count", grants.size(), 2);
        if (grants.size() > 0) check("post_rst_first_grant", grants[0], 0);

        for (int batch = 0; batch < 6; batch++) begin
            en_div = ($urandom_range(0, 3) == 0) ? 3 : 1;
            repeat (5) @(posedge clk);
            for (int f = 0; f < int'($urandom_range(1, 4)); f++) begin
                len = $urandom_range(1, 90);
                sa  = -1;
                sn  = 0;
                if (len > 1 && $urandom_range(0, 2) == 0) begin
                    sa = $urandom_range(1, len - 1);
                    sn = $urandom_range(1, 3);
                end
                send($urandom_range(0, N - 1), len, 1'b0, sa, sn);
            end
            wait_done(20000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
